// File: rtl/umi_decode_pipe.sv
// UMI command decoder with a registered output stage and one skid entry.
// Classifies commands, optionally drops invalid packets, and keeps saturating event counters.
module umi_decode_pipe #(
  parameter int CW           = 32,
  parameter int AW           = 64,
  parameter int DW           = 256,
  parameter int CNTW         = 16,
  parameter int DROP_INVALID = 1,
  parameter int ATOMIC_CHECK = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [CW-1:0]   in_cmd,
  input  logic [AW-1:0]   in_dstaddr,
  input  logic [AW-1:0]   in_srcaddr,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [CW-1:0]   out_cmd,
  output logic [AW-1:0]   out_dstaddr,
  output logic [AW-1:0]   out_srcaddr,
  output logic [DW-1:0]   out_data,
  output logic [15:0]     out_class,
  output logic [8:0]      out_atomic_op,
  output logic            out_err,
  input  logic            out_ready,
  input  logic            cnt_clear,
  output logic [CNTW-1:0] cnt_req,
  output logic [CNTW-1:0] cnt_resp,
  output logic [CNTW-1:0] cnt_drop,
  output logic [CNTW-1:0] cnt_err
);

  localparam logic [7:0] UMI_INVALID      = 8'h00;
  localparam logic [7:0] UMI_REQ_ERROR    = 8'h0F;
  localparam logic [7:0] UMI_REQ_LINK     = 8'h2F;
  localparam logic [7:0] UMI_RESP_LINK    = 8'h0E;
  localparam logic [3:0] UMI_REQ_READ     = 4'h1;
  localparam logic [3:0] UMI_REQ_WRITE    = 4'h3;
  localparam logic [3:0] UMI_REQ_POSTED   = 4'h5;
  localparam logic [3:0] UMI_REQ_RDMA     = 4'h7;
  localparam logic [3:0] UMI_REQ_ATOMIC   = 4'h9;
  localparam logic [3:0] UMI_REQ_USER0    = 4'hB;
  localparam logic [3:0] UMI_REQ_FUTURE0  = 4'hD;
  localparam logic [3:0] UMI_RESP_READ    = 4'h2;
  localparam logic [3:0] UMI_RESP_WRITE   = 4'h4;
  localparam logic [3:0] UMI_RESP_USER0   = 4'h6;
  localparam logic [3:0] UMI_RESP_USER1   = 4'h8;
  localparam logic [3:0] UMI_RESP_FUTURE0 = 4'hA;
  localparam logic [3:0] UMI_RESP_FUTURE1 = 4'hC;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
    logic [15:0]   cls;
    logic [8:0]    atom;
    logic          err;
  } pkt_t;

  pkt_t in_pkt, out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
  logic in_inv, accept, drop, keep, out_free, out_fire, out_inv;
  logic is_req;
  logic [3:0] nib;
  logic [15:0] cls;
  logic [8:0] atom;
  logic [CNTW-1:0] cnt_req_q, cnt_resp_q, cnt_drop_q, cnt_err_q;

  always_comb begin
    nib    = in_cmd[3:0];
    is_req = in_cmd[0];
    in_inv = (in_cmd[7:0] == UMI_INVALID);
    cls    = '0;
    if (!in_inv) begin
      cls[0]  = is_req && (nib == UMI_REQ_READ);
      cls[1]  = is_req && (nib == UMI_REQ_WRITE);
      cls[2]  = is_req && (nib == UMI_REQ_POSTED);
      cls[3]  = is_req && (nib == UMI_REQ_RDMA);
      cls[4]  = is_req && (nib == UMI_REQ_ATOMIC);
      cls[5]  = is_req && (nib == UMI_REQ_USER0);
      cls[6]  = is_req && (nib == UMI_REQ_FUTURE0);
      cls[7]  = (in_cmd[7:0] == UMI_REQ_ERROR);
      cls[8]  = (in_cmd[7:0] == UMI_REQ_LINK);
      cls[9]  = !is_req && (nib == UMI_RESP_READ);
      cls[10] = !is_req && (nib == UMI_RESP_WRITE);
      cls[11] = !is_req && (nib == UMI_RESP_USER0);
      cls[12] = !is_req && (nib == UMI_RESP_USER1);
      cls[13] = !is_req && (nib == UMI_RESP_FUTURE0);
      cls[14] = !is_req && (nib == UMI_RESP_FUTURE1);
      cls[15] = (in_cmd[7:0] == UMI_RESP_LINK);
      // full-byte matches win over nibble matches to keep the vector one-hot
      if (cls[7] || cls[8]) cls[6:0] = '0;
      if (cls[15]) cls[14:9] = '0;
    end
    // atomic sub-op codes are 0 (add) through 8 (swap)
    atom = '0;
    for (int i = 0; i < 9; i++) atom[i] = cls[4] && (in_cmd[15:8] == 8'(i));
    in_pkt = '{cmd: in_cmd, dst: in_dstaddr, src: in_srcaddr, data: in_data,
               cls: cls, atom: atom, err: (ATOMIC_CHECK != 0) && cls[4] && (atom == '0)};
  end

  always_comb begin
    accept       = in_valid && in_ready_q;
    drop         = accept && in_inv && (DROP_INVALID != 0);
    keep         = accept && !drop;
    out_free     = !out_valid_q || out_ready;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = keep;
        if (keep) skid_d = in_pkt;
      end else begin
        out_valid_d = keep;
        if (keep) out_d = in_pkt;
      end
    end else if (keep) begin
      skid_d       = in_pkt;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  assign out_fire = out_valid_q && out_ready;
  assign out_inv  = (out_q.cmd[7:0] == UMI_INVALID);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c, input logic ev,
                                              input logic clr);
    if (clr) return '0;
    if (ev && (c != {CNTW{1'b1}})) return c + 1'b1;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_req_q    <= '0;
      cnt_resp_q   <= '0;
      cnt_drop_q   <= '0;
      cnt_err_q    <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_req_q    <= sat_inc(cnt_req_q, out_fire && !out_inv && out_q.cmd[0], cnt_clear);
      cnt_resp_q   <= sat_inc(cnt_resp_q, out_fire && !out_inv && !out_q.cmd[0], cnt_clear);
      cnt_drop_q   <= sat_inc(cnt_drop_q, drop, cnt_clear);
      cnt_err_q    <= sat_inc(cnt_err_q, out_fire && out_q.err, cnt_clear);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_cmd       = out_q.cmd;
  assign out_dstaddr   = out_q.dst;
  assign out_srcaddr   = out_q.src;
  assign out_data      = out_q.data;
  assign out_class     = out_q.cls;
  assign out_atomic_op = out_q.atom;
  assign out_err       = out_q.err;
  assign cnt_req       = cnt_req_q;
  assign cnt_resp      = cnt_resp_q;
  assign cnt_drop      = cnt_drop_q;
  assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_umi_decode_pipe.sv
// Bench for umi_decode_pipe: decode vector table, scoreboard on the main instance,
// and a second instance with dropping/atomic checking off and 4-bit counters.
module tb_umi_decode_pipe;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, out_ready, cnt_clear;
  logic [CW-1:0] in_cmd;
  logic [AW-1:0] in_dstaddr, in_srcaddr;
  logic [DW-1:0] in_data;

  logic in_ready, out_valid, out_err;
  logic [CW-1:0] out_cmd;
  logic [AW-1:0] out_dstaddr, out_srcaddr;
  logic [DW-1:0] out_data;
  logic [15:0] out_class;
  logic [8:0] out_atomic_op;
  logic [15:0] cnt_req, cnt_resp, cnt_drop, cnt_err;

  logic b_in_ready, b_out_valid, b_out_err;
  logic [CW-1:0] b_out_cmd;
  logic [AW-1:0] b_out_dstaddr, b_out_srcaddr;
  logic [DW-1:0] b_out_data;
  logic [15:0] b_out_class;
  logic [8:0] b_out_atomic_op;
  logic [3:0] b_cnt_req, b_cnt_resp, b_cnt_drop, b_cnt_err;

  umi_decode_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_cmd(in_cmd),
    .in_dstaddr(in_dstaddr), .in_srcaddr(in_srcaddr), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_cmd(out_cmd),
    .out_dstaddr(out_dstaddr), .out_srcaddr(out_srcaddr), .out_data(out_data),
    .out_class(out_class), .out_atomic_op(out_atomic_op), .out_err(out_err),
    .out_ready(out_ready), .cnt_clear(cnt_clear), .cnt_req(cnt_req),
    .cnt_resp(cnt_resp), .cnt_drop(cnt_drop), .cnt_err(cnt_err)
  );

  umi_decode_pipe #(.CNTW(4), .DROP_INVALID(0), .ATOMIC_CHECK(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_cmd(in_cmd),
    .in_dstaddr(in_dstaddr), .in_srcaddr(in_srcaddr), .in_data(in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_cmd(b_out_cmd),
    .out_dstaddr(b_out_dstaddr), .out_srcaddr(b_out_srcaddr), .out_data(b_out_data),
    .out_class(b_out_class), .out_atomic_op(b_out_atomic_op), .out_err(b_out_err),
    .out_ready(out_ready), .cnt_clear(cnt_clear), .cnt_req(b_cnt_req),
    .cnt_resp(b_cnt_resp), .cnt_drop(b_cnt_drop), .cnt_err(b_cnt_err)
  );

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
    logic [15:0]   cls;
    logic [8:0]    atom;
    logic          err;
    int            t;
  } exp_t;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] cls;
    logic [8:0]  atom;
    logic        err;
    logic        inv;
  } vec_t;

  exp_t q[$];
  vec_t vec[25];
  logic [15:0] d_cls;
  logic [8:0]  d_atom;
  logic        d_err, d_drop;
  int total = 0, bad = 0, cyc = 0, stall_acc = 0;
  bit lat_chk = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the packet on the input until it is accepted; leaves in_valid high.
  task automatic send(input logic [CW-1:0] cmd, input logic [15:0] cls, input logic [8:0] atom,
                      input logic err, input logic drop);
    bit acc;
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_cmd     = cmd;
    in_dstaddr = {$urandom, $urandom};
    in_srcaddr = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom;
    d_cls  = cls;
    d_atom = atom;
    d_err  = err;
    d_drop = drop;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", acc, 1);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          chk("out_cmd", out_cmd, q[0].cmd);
          chk("out_dstaddr", out_dstaddr, q[0].dst);
          chk("out_srcaddr", out_srcaddr, q[0].src);
          chk("out_data", out_data, q[0].data);
          chk("out_class", out_class, q[0].cls);
          chk("out_atomic_op", out_atomic_op, q[0].atom);
          chk("out_err", out_err, q[0].err);
          if (out_ready) begin
            if (lat_chk) chk("latency", cyc - q[0].t, 1);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready && !out_ready) stall_acc++;
      if (in_valid && in_ready && !d_drop)
        q.push_back('{in_cmd, in_dstaddr, in_srcaddr, in_data, d_cls, d_atom, d_err, cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] hi;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    in_cmd = '0; in_dstaddr = '0; in_srcaddr = '0; in_data = '0;
    d_cls = '0; d_atom = '0; d_err = 1'b0; d_drop = 1'b0;

    vec[0]  = '{16'h0001, 16'h0001, 9'h000, 1'b0, 1'b0};
    vec[1]  = '{16'h0003, 16'h0002, 9'h000, 1'b0, 1'b0};
    vec[2]  = '{16'h0005, 16'h0004, 9'h000, 1'b0, 1'b0};
    vec[3]  = '{16'h0007, 16'h0008, 9'h000, 1'b0, 1'b0};
    vec[4]  = '{16'h0809, 16'h0010, 9'h100, 1'b0, 1'b0};
    vec[5]  = '{16'h0009, 16'h0010, 9'h001, 1'b0, 1'b0};
    vec[6]  = '{16'h0609, 16'h0010, 9'h040, 1'b0, 1'b0};
    vec[7]  = '{16'hFF09, 16'h0010, 9'h000, 1'b1, 1'b0};
    vec[8]  = '{16'h000B, 16'h0020, 9'h000, 1'b0, 1'b0};
    vec[9]  = '{16'h000D, 16'h0040, 9'h000, 1'b0, 1'b0};
    vec[10] = '{16'h000F, 16'h0080, 9'h000, 1'b0, 1'b0};
    vec[11] = '{16'h002F, 16'h0100, 9'h000, 1'b0, 1'b0};
    vec[12] = '{16'h0002, 16'h0200, 9'h000, 1'b0, 1'b0};
    vec[13] = '{16'h0004, 16'h0400, 9'h000, 1'b0, 1'b0};
    vec[14] = '{16'h0006, 16'h0800, 9'h000, 1'b0, 1'b0};
    vec[15] = '{16'h0008, 16'h1000, 9'h000, 1'b0, 1'b0};
    vec[16] = '{16'h000A, 16'h2000, 9'h000, 1'b0, 1'b0};
    vec[17] = '{16'h000C, 16'h4000, 9'h000, 1'b0, 1'b0};
    vec[18] = '{16'h000E, 16'h8000, 9'h000, 1'b0, 1'b0};
    vec[19] = '{16'h001F, 16'h0000, 9'h000, 1'b0, 1'b0};
    vec[20] = '{16'h001E, 16'h0000, 9'h000, 1'b0, 1'b0};
    vec[21] = '{16'h0012, 16'h0200, 9'h000, 1'b0, 1'b0};
    vec[22] = '{16'h0000, 16'h0000, 9'h000, 1'b0, 1'b1};
    vec[23] = '{16'hAB00, 16'h0000, 9'h000, 1'b0, 1'b1};
    vec[24] = '{16'h0309, 16'h0010, 9'h008, 1'b0, 1'b0};

    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_cmd", out_cmd, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cnt_req", cnt_req, 0);
    reset = 1'b0;
    step();
    chk("in_ready_after_reset", in_ready, 1);

    // back-to-back writes at full throughput
    lat_chk = 1;
    for (int i = 0; i < 20; i++) begin
      hi = 24'($urandom);
      send({hi, 8'h03}, 16'h0002, 9'h000, 1'b0, 1'b0);
      chk("wr_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step(); step();
    chk("wr_cnt_req", cnt_req, 20);
    chk("wr_cnt_resp", cnt_resp, 0);
    chk("b_cnt_req_sat", b_cnt_req, 15);

    // clear coincident with an output transfer
    send({24'h0, 8'h03}, 16'h0002, 9'h000, 1'b0, 1'b0);
    in_valid  = 1'b0;
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_cnt_req", cnt_req, 0);
    chk("b_clr_cnt_req", b_cnt_req, 0);
    step();

    for (int i = 0; i < 25; i++) begin
      send({16'hA5C3, vec[i].cmd}, vec[i].cls, vec[i].atom, vec[i].err, vec[i].inv);
      chk("b_valid", b_out_valid, 1);
      chk("b_class", b_out_class, vec[i].cls);
      chk("b_atom", b_out_atomic_op, vec[i].atom);
      chk("b_err", b_out_err, 0);
    end
    in_valid = 1'b0;
    step(); step();
    chk("vec_cnt_req", cnt_req, 14);
    chk("vec_cnt_resp", cnt_resp, 9);
    chk("vec_cnt_drop", cnt_drop, 2);
    chk("vec_cnt_err", cnt_err, 1);
    chk("b_vec_cnt_req", b_cnt_req, 14);
    chk("b_vec_cnt_resp", b_cnt_resp, 9);
    chk("b_vec_cnt_drop", b_cnt_drop, 0);
    chk("b_vec_cnt_err", b_cnt_err, 0);

    // stall: out_ready low for 3 cycles starting on the third read
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("stall_clr", cnt_req, 0);
    stall_acc = 0;
    lat_chk   = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send({16'h0, 8'(i), 8'h01}, 16'h0001, 9'h000, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        step(); step();
        out_ready = 1'b0;
        step();
        chk("stall_in_ready", in_ready, 0);
        step(); step();
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("stall_accepts", stall_acc, 1);
    chk("stall_cnt_req", cnt_req, 4);
    chk("stall_drained", q.size(), 0);

    // reset with output and skid both occupied
    out_ready = 1'b0;
    send({24'h0, 8'h01}, 16'h0001, 9'h000, 1'b0, 1'b0);
    send({24'h1, 8'h01}, 16'h0001, 9'h000, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cnt_req", cnt_req, 0);
    chk("mid_rst_out_class", out_class, 0);
    chk("mid_rst_out_cmd", out_cmd, 0);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    lat_chk = 1;
    send({24'h77, 8'h03}, 16'h0002, 9'h000, 1'b0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    chk("post_rst_drained", q.size(), 0);
    chk("post_rst_cnt_req", cnt_req, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
